// File: rtl/spu_lsu_stresp.sv
// LSU responder for SPU store requests: buffers stores in a small FIFO, issues
// them on PCX one at a time, and returns one in-order streq_ack per L2 store ack.
module spu_lsu_stresp #(
  parameter int PA_WIDTH   = 40,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  rclk,
  input  logic                  arst_l,
  input  logic                  se,
  input  logic                  spu_lsu_streq,
  input  logic [PA_WIDTH-1:0]   spu_lsu_st_addr,
  input  logic [DATA_WIDTH-1:0] spu_lsu_st_data,
  input  logic [1:0]            spu_lsu_st_tid,
  input  logic                  spu_lsu_abort,
  output logic                  pcx_req,
  output logic [PA_WIDTH-1:0]   pcx_addr,
  output logic [DATA_WIDTH-1:0] pcx_data,
  output logic [1:0]            pcx_tid,
  input  logic                  pcx_grant,
  input  logic                  cpx_st_ack,
  output logic                  lsu_spu_streq_ack,
  output logic                  lsu_spu_st_pend,
  output logic                  lsu_spu_st_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + PA_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAITACK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d;
  logic          ack_q, ack_d, ovf_q, ovf_d;
  logic          full, push_ok, grant_ok, ack_ok;
  logic [EW-1:0] entry_mem [DEPTH];
  logic [EW-1:0] head;
  logic          unused_se;

  // No scan flops are modelled here; scan enable is accepted for port compatibility.
  assign unused_se = se;

  always_comb begin
    full     = (count_q == DEPTH_C);
    push_ok  = spu_lsu_streq && !spu_lsu_abort && !full;
    grant_ok = (state_q == REQ) && pcx_grant;
    ack_ok   = cpx_st_ack && (outst_q != '0);
    ack_d    = ack_ok;
    ovf_d    = ovf_q || (spu_lsu_streq && !spu_lsu_abort && full) ||
               (cpx_st_ack && (outst_q == '0));
    outst_d  = outst_q + CW'(grant_ok) - CW'(ack_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (spu_lsu_abort) begin
      // A grant in the abort cycle is still counted above; only the queue is flushed.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (grant_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(grant_ok);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = REQ;
      end
      REQ, WAITACK: begin
        if ((count_d != '0) && (outst_d < DEPTH_C))      state_d = REQ;
        else if ((count_d == '0) && (outst_d == '0))     state_d = IDLE;
        else                                             state_d = WAITACK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage carries no reset; its contents are only visible while pcx_req is up.
  always_ff @(posedge rclk) begin
    if (push_ok) entry_mem[wr_ptr_q] <= {spu_lsu_st_tid, spu_lsu_st_addr, spu_lsu_st_data};
  end

  always_comb begin
    head              = entry_mem[rd_ptr_q];
    pcx_req           = (state_q == REQ);
    pcx_tid           = pcx_req ? head[EW-1 -: 2] : 2'b0;
    pcx_addr          = pcx_req ? head[DATA_WIDTH +: PA_WIDTH] : '0;
    pcx_data          = pcx_req ? head[DATA_WIDTH-1:0] : '0;
    lsu_spu_streq_ack = ack_q;
    lsu_spu_st_pend   = (count_q != '0) || (outst_q != '0);
    lsu_spu_st_ovf    = ovf_q;
  end

endmodule
